// File: rtl/jogo_pkg.sv
// Shared definitions for the memory-game control unit: state codes shown on the
// debug display and the default per-play time limit.
package jogo_pkg;

    localparam int TIMEOUT_CICLOS_PADRAO = 5000;

    localparam logic [3:0] INICIAL        = 4'h0;
    localparam logic [3:0] PREPARACAO     = 4'h1;
    localparam logic [3:0] INICIA_RODADA  = 4'h2;
    localparam logic [3:0] ESPERA_JOGADA  = 4'h3;
    localparam logic [3:0] REGISTRA       = 4'h4;
    localparam logic [3:0] COMPARACAO     = 4'h5;
    localparam logic [3:0] PROXIMA_JOGADA = 4'h6;
    localparam logic [3:0] PROXIMA_RODADA = 4'h7;
    localparam logic [3:0] FIM_ACERTO     = 4'hA;
    localparam logic [3:0] FIM_TIMEOUT    = 4'hB;
    localparam logic [3:0] FIM_ERRO       = 4'hE;

    // Enum values are tied to the display codes so db_estado is the raw state.
    typedef enum logic [3:0] {
        S_INICIAL        = INICIAL,
        S_PREPARACAO     = PREPARACAO,
        S_INICIA_RODADA  = INICIA_RODADA,
        S_ESPERA_JOGADA  = ESPERA_JOGADA,
        S_REGISTRA       = REGISTRA,
        S_COMPARACAO     = COMPARACAO,
        S_PROXIMA_JOGADA = PROXIMA_JOGADA,
        S_PROXIMA_RODADA = PROXIMA_RODADA,
        S_FIM_ACERTO     = FIM_ACERTO,
        S_FIM_TIMEOUT    = FIM_TIMEOUT,
        S_FIM_ERRO       = FIM_ERRO
    } estado_t;

endpackage

// File: rtl/controle_rodadas_jogo_if.sv
// Signals between the game control unit (master) and the datapath (slave).
interface controle_rodadas_jogo_if;

    logic       iniciar;
    logic       jogada_feita;
    logic       jogada_correta;
    logic       fim_jogadas;
    logic       fim_rodadas;
    logic       zera_endereco;
    logic       conta_endereco;
    logic       zera_limite;
    logic       conta_limite;
    logic       zera_jogada;
    logic       registra_jogada;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, jogada_feita, jogada_correta, fim_jogadas, fim_rodadas,
        output zera_endereco, conta_endereco, zera_limite, conta_limite,
               zera_jogada, registra_jogada, pronto, acertou, errou, timeout,
               db_estado
    );

    modport slave (
        output iniciar, jogada_feita, jogada_correta, fim_jogadas, fim_rodadas,
        input  zera_endereco, conta_endereco, zera_limite, conta_limite,
               zera_jogada, registra_jogada, pronto, acertou, errou, timeout,
               db_estado
    );

endinterface

// File: rtl/contador_timeout.sv
// Per-play cycle counter: clears on zera, advances on conta, saturates at M-1
// and flags the terminal count on fim.
module contador_timeout #(
    parameter int M = 5000
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int W = $clog2(M);
    localparam logic [W-1:0] ULTIMO = W'(M - 1);

    logic [W-1:0] contagem_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem_reg <= '0;
        end else if (zera) begin
            contagem_reg <= '0;
        end else if (conta && (contagem_reg != ULTIMO)) begin
            contagem_reg <= contagem_reg + 1'b1;
        end
    end

    assign fim = (contagem_reg == ULTIMO);

endmodule

// File: rtl/controle_rodadas_jogo.sv
// Moore control unit of the memory game: sequences rounds and plays, drives all
// datapath enables and reports win, wrong play or play timeout.
module controle_rodadas_jogo
    import jogo_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
    input  logic                     clock,
    input  logic                     reset,
    controle_rodadas_jogo_if.master  bus
);

    estado_t estado_reg;
    estado_t estado_next;
    logic    fim_contagem;
    logic    zera_contagem;
    logic    conta_contagem;

    // Timer restarts on every new round and every new play within a round.
    assign zera_contagem  = (estado_reg == S_INICIA_RODADA) || (estado_reg == S_PROXIMA_JOGADA);
    assign conta_contagem = (estado_reg == S_ESPERA_JOGADA);

    contador_timeout #(
        .M (TIMEOUT_CICLOS)
    ) u_contador_timeout (
        .clock (clock),
        .reset (reset),
        .zera  (zera_contagem),
        .conta (conta_contagem),
        .fim   (fim_contagem)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_reg <= S_INICIAL;
        end else begin
            estado_reg <= estado_next;
        end
    end

    always_comb begin
        estado_next         = estado_reg;
        bus.zera_endereco   = 1'b0;
        bus.conta_endereco  = 1'b0;
        bus.zera_limite     = 1'b0;
        bus.conta_limite    = 1'b0;
        bus.zera_jogada     = 1'b0;
        bus.registra_jogada = 1'b0;
        bus.pronto          = 1'b0;
        bus.acertou         = 1'b0;
        bus.errou           = 1'b0;
        bus.timeout         = 1'b0;

        case (estado_reg)
            S_INICIAL: begin
                if (bus.iniciar) estado_next = S_PREPARACAO;
            end
            S_PREPARACAO: begin
                bus.zera_endereco = 1'b1;
                bus.zera_limite   = 1'b1;
                bus.zera_jogada   = 1'b1;
                estado_next       = S_INICIA_RODADA;
            end
            S_INICIA_RODADA: begin
                bus.zera_endereco = 1'b1;
                estado_next       = S_ESPERA_JOGADA;
            end
            S_ESPERA_JOGADA: begin
                // A play arriving on the terminal count still counts as made in time.
                if (bus.jogada_feita)  estado_next = S_REGISTRA;
                else if (fim_contagem) estado_next = S_FIM_TIMEOUT;
            end
            S_REGISTRA: begin
                bus.registra_jogada = 1'b1;
                estado_next         = S_COMPARACAO;
            end
            S_COMPARACAO: begin
                if (!bus.jogada_correta)   estado_next = S_FIM_ERRO;
                else if (!bus.fim_jogadas) estado_next = S_PROXIMA_JOGADA;
                else if (!bus.fim_rodadas) estado_next = S_PROXIMA_RODADA;
                else                       estado_next = S_FIM_ACERTO;
            end
            S_PROXIMA_JOGADA: begin
                bus.conta_endereco = 1'b1;
                estado_next        = S_ESPERA_JOGADA;
            end
            S_PROXIMA_RODADA: begin
                bus.conta_limite = 1'b1;
                estado_next      = S_INICIA_RODADA;
            end
            S_FIM_ACERTO: begin
                bus.pronto  = 1'b1;
                bus.acertou = 1'b1;
                if (bus.iniciar) estado_next = S_PREPARACAO;
            end
            S_FIM_ERRO: begin
                bus.pronto = 1'b1;
                bus.errou  = 1'b1;
                if (bus.iniciar) estado_next = S_PREPARACAO;
            end
            S_FIM_TIMEOUT: begin
                bus.pronto  = 1'b1;
                bus.timeout = 1'b1;
                if (bus.iniciar) estado_next = S_PREPARACAO;
            end
            default: begin
                estado_next = S_INICIAL;
            end
        endcase
    end

    assign bus.db_estado = estado_reg;

endmodule

// File: tb/tb_controle_rodadas_jogo.sv
// Bench for the game control unit: datapath model around the DUT, expected
// state/output vectors queued at stimulus time and checked on the falling edge.
module tb_controle_rodadas_jogo;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    controle_rodadas_jogo_if bus();

    controle_rodadas_jogo #(
        .TIMEOUT_CICLOS (5000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // {zera_end, conta_end, zera_lim, conta_lim, zera_jog, reg_jog, pronto, acertou, errou, timeout}
    localparam logic [9:0] O_NADA    = 10'b0000000000;
    localparam logic [9:0] O_PREP    = 10'b1010100000;
    localparam logic [9:0] O_INICIA  = 10'b1000000000;
    localparam logic [9:0] O_REG     = 10'b0000010000;
    localparam logic [9:0] O_ACERTO  = 10'b0000001100;
    localparam logic [9:0] O_ERRO    = 10'b0000001010;
    localparam logic [9:0] O_TIMEOUT = 10'b0000001001;

    typedef struct packed {
        logic [3:0] est;
        logic [9:0] o;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Datapath model: address and round-limit counters driven by the DUT enables.
    logic [3:0] addr_m    = 4'd0;
    logic [3:0] lim_m     = 4'd0;
    logic       correta_m = 1'b1;
    int         n_pulsos_lim = 0;
    int         n_pulsos_end = 0;

    assign bus.jogada_correta = correta_m;
    assign bus.fim_jogadas    = (addr_m == lim_m);
    assign bus.fim_rodadas    = (lim_m == 4'd3);

    always @(posedge clock) begin
        if (bus.zera_endereco)       addr_m <= 4'd0;
        else if (bus.conta_endereco) addr_m <= addr_m + 4'd1;
        if (bus.zera_limite)         lim_m  <= 4'd0;
        else if (bus.conta_limite)   lim_m  <= lim_m + 4'd1;
        if (bus.conta_limite)   n_pulsos_lim <= n_pulsos_lim + 1;
        if (bus.conta_endereco) n_pulsos_end <= n_pulsos_end + 1;
    end

    function automatic logic [9:0] outs();
        return {bus.zera_endereco, bus.conta_endereco, bus.zera_limite, bus.conta_limite,
                bus.zera_jogada, bus.registra_jogada, bus.pronto, bus.acertou,
                bus.errou, bus.timeout};
    endfunction

    task automatic esperar_estado(input logic [3:0] alvo, input int limite, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limite; i++) begin
            if (bus.db_estado === alvo) begin
                ok = 1'b1;
                return;
            end
            @(negedge clock);
        end
    endtask

    // Async reset, then one-cycle iniciar; returns on the first falling edge in state 3.
    task automatic iniciar_jogo();
        bit ok;
        @(negedge clock);
        reset = 1'b0;
        bus.iniciar = 1'b0;
        bus.jogada_feita = 1'b0;
        correta_m = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        bus.iniciar = 1'b1;
        @(negedge clock);
        bus.iniciar = 1'b0;
        esperar_estado(4'h3, 5, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL start_game: estado=%h, required estado=3", bus.db_estado);
        end
    endtask

    // Plays every espera_jogada; the play at (erro_lim, erro_addr) is made wrong.
    task automatic jogar(input int erro_lim, input int erro_addr);
        for (int c = 0; c < 400; c++) begin
            if (bus.db_estado === 4'hA || bus.db_estado === 4'hE || bus.db_estado === 4'hB) break;
            if (bus.db_estado === 4'h3) begin
                if (int'(lim_m) == erro_lim && int'(addr_m) == erro_addr) correta_m = 1'b0;
                bus.jogada_feita = 1'b1;
            end else begin
                bus.jogada_feita = 1'b0;
            end
            @(negedge clock);
        end
        bus.jogada_feita = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b0;
        bus.iniciar = 1'b0;
        bus.jogada_feita = 1'b0;
        repeat (10) @(negedge clock);
        sb.push_back('{4'h0, O_NADA});
        e = sb.pop_front(); n_vec++;
        if (bus.db_estado !== e.est || outs() !== e.o) begin
            n_err++;
            $display("FAIL reset_state: estado=%h outs=%b, required estado=%h outs=%b", bus.db_estado, outs(), e.est, e.o);
        end else $display("vector reset_state estado=%h outs=%b", bus.db_estado, outs());
        reset = 1'b1;
        @(negedge clock);
        sb.push_back('{4'h0, O_NADA});
        e = sb.pop_front(); n_vec++;
        if (bus.db_estado !== e.est || outs() !== e.o) begin
            n_err++;
            $display("FAIL idle_no_iniciar: estado=%h outs=%b, required estado=%h outs=%b", bus.db_estado, outs(), e.est, e.o);
        end else $display("vector idle_no_iniciar estado=%h", bus.db_estado);
        bus.iniciar = 1'b1;
        sb.push_back('{4'h1, O_PREP});
        sb.push_back('{4'h2, O_INICIA});
        sb.push_back('{4'h3, O_NADA});
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            bus.iniciar = 1'b0;
            e = sb.pop_front(); n_vec++;
            if (bus.db_estado !== e.est || outs() !== e.o) begin
                n_err++;
                $display("FAIL start_seq[%0d]: estado=%h outs=%b, required estado=%h outs=%b", i, bus.db_estado, outs(), e.est, e.o);
            end else $display("vector start_seq[%0d] estado=%h outs=%b", i, bus.db_estado, outs());
        end
    endtask

    task automatic test_vitoria();
        exp_t e;
        int   lim0, end0;
        iniciar_jogo();
        lim0 = n_pulsos_lim;
        end0 = n_pulsos_end;
        sb.push_back('{4'hA, O_ACERTO});
        jogar(-1, -1);
        e = sb.pop_front(); n_vec++;
        if (bus.db_estado !== e.est || outs() !== e.o) begin
            n_err++;
            $display("FAIL win_final: estado=%h outs=%b, required estado=%h outs=%b", bus.db_estado, outs(), e.est, e.o);
        end else $display("vector win_final estado=%h outs=%b", bus.db_estado, outs());
        n_vec++;
        if (n_pulsos_lim - lim0 !== 3) begin
            n_err++;
            $display("FAIL win_conta_limite: pulses=%0d, required 3", n_pulsos_lim - lim0);
        end else $display("vector win_conta_limite pulses=%0d", n_pulsos_lim - lim0);
        n_vec++;
        if (n_pulsos_end - end0 !== 6) begin
            n_err++;
            $display("FAIL win_conta_endereco: pulses=%0d, required 6", n_pulsos_end - end0);
        end else $display("vector win_conta_endereco pulses=%0d", n_pulsos_end - end0);
        sb.push_back('{4'hA, O_ACERTO});
        repeat (3) @(negedge clock);
        e = sb.pop_front(); n_vec++;
        if (bus.db_estado !== e.est || outs() !== e.o) begin
            n_err++;
            $display("FAIL win_hold: estado=%h outs=%b, required estado=%h outs=%b", bus.db_estado, outs(), e.est, e.o);
        end else $display("vector win_hold estado=%h", bus.db_estado);
    endtask

    task automatic test_erro();
        exp_t e;
        iniciar_jogo();
        sb.push_back('{4'hE, O_ERRO});
        jogar(3, 2);
        e = sb.pop_front(); n_vec++;
        if (bus.db_estado !== e.est || outs() !== e.o || lim_m !== 4'd3 || addr_m !== 4'd2) begin
            n_err++;
            $display("FAIL error_round4: estado=%h outs=%b lim=%0d addr=%0d, required estado=%h outs=%b lim=3 addr=2",
                     bus.db_estado, outs(), lim_m, addr_m, e.est, e.o);
        end else $display("vector error_round4 estado=%h outs=%b", bus.db_estado, outs());
        correta_m = 1'b1;
        bus.iniciar = 1'b1;
        sb.push_back('{4'h1, O_PREP});
        @(negedge clock);
        bus.iniciar = 1'b0;
        e = sb.pop_front(); n_vec++;
        if (bus.db_estado !== e.est || outs() !== e.o) begin
            n_err++;
            $display("FAIL error_restart: estado=%h outs=%b, required estado=%h outs=%b", bus.db_estado, outs(), e.est, e.o);
        end else $display("vector error_restart estado=%h outs=%b", bus.db_estado, outs());
    endtask

    task automatic test_timeout();
        exp_t e;
        int   n;
        iniciar_jogo();
        sb.push_back('{4'hB, O_TIMEOUT});
        for (n = 1; n <= 6000; n++) begin
            @(negedge clock);
            if (bus.db_estado !== 4'h3) break;
        end
        n_vec++;
        if (n !== 5000) begin
            n_err++;
            $display("FAIL timeout_cycles: left state 3 after %0d cycles, required 5000", n);
        end else $display("vector timeout_cycles n=%0d", n);
        e = sb.pop_front(); n_vec++;
        if (bus.db_estado !== e.est || outs() !== e.o) begin
            n_err++;
            $display("FAIL timeout_state: estado=%h outs=%b, required estado=%h outs=%b", bus.db_estado, outs(), e.est, e.o);
        end else $display("vector timeout_state estado=%h outs=%b", bus.db_estado, outs());

        iniciar_jogo();
        sb.push_back('{4'h3, O_NADA});
        sb.push_back('{4'h4, O_REG});
        repeat (4999) @(negedge clock);
        e = sb.pop_front(); n_vec++;
        if (bus.db_estado !== e.est || outs() !== e.o) begin
            n_err++;
            $display("FAIL timeout_last_wait: estado=%h outs=%b, required estado=%h outs=%b", bus.db_estado, outs(), e.est, e.o);
        end else $display("vector timeout_last_wait estado=%h", bus.db_estado);
        bus.jogada_feita = 1'b1;
        @(negedge clock);
        bus.jogada_feita = 1'b0;
        e = sb.pop_front(); n_vec++;
        if (bus.db_estado !== e.est || outs() !== e.o) begin
            n_err++;
            $display("FAIL timeout_play_wins: estado=%h outs=%b, required estado=%h outs=%b", bus.db_estado, outs(), e.est, e.o);
        end else $display("vector timeout_play_wins estado=%h outs=%b", bus.db_estado, outs());
    endtask

    task automatic test_reset_assincrono();
        exp_t e;
        iniciar_jogo();
        repeat (3) @(negedge clock);
        sb.push_back('{4'h0, O_NADA});
        #2 reset = 1'b0;
        #1;
        e = sb.pop_front(); n_vec++;
        if (bus.db_estado !== e.est || outs() !== e.o) begin
            n_err++;
            $display("FAIL async_reset: estado=%h outs=%b, required estado=%h outs=%b", bus.db_estado, outs(), e.est, e.o);
        end else $display("vector async_reset estado=%h", bus.db_estado);
        @(negedge clock);
        reset = 1'b1;
        sb.push_back('{4'h0, O_NADA});
        repeat (3) @(negedge clock);
        e = sb.pop_front(); n_vec++;
        if (bus.db_estado !== e.est || outs() !== e.o) begin
            n_err++;
            $display("FAIL async_reset_idle: estado=%h outs=%b, required estado=%h outs=%b", bus.db_estado, outs(), e.est, e.o);
        end else $display("vector async_reset_idle estado=%h", bus.db_estado);
        bus.iniciar = 1'b1;
        sb.push_back('{4'h1, O_PREP});
        @(negedge clock);
        bus.iniciar = 1'b0;
        e = sb.pop_front(); n_vec++;
        if (bus.db_estado !== e.est || outs() !== e.o) begin
            n_err++;
            $display("FAIL async_reset_restart: estado=%h outs=%b, required estado=%h outs=%b", bus.db_estado, outs(), e.est, e.o);
        end else $display("vector async_reset_restart estado=%h", bus.db_estado);
    endtask

    task automatic test_robustez();
        exp_t e;
        bit   ok;
        iniciar_jogo();
        bus.iniciar = 1'b1;
        sb.push_back('{4'h3, O_NADA});
        repeat (3) @(negedge clock);
        bus.iniciar = 1'b0;
        e = sb.pop_front(); n_vec++;
        if (bus.db_estado !== e.est || outs() !== e.o) begin
            n_err++;
            $display("FAIL iniciar_ignored: estado=%h outs=%b, required estado=%h outs=%b", bus.db_estado, outs(), e.est, e.o);
        end else $display("vector iniciar_ignored estado=%h", bus.db_estado);
        bus.jogada_feita = 1'b1;
        @(negedge clock);
        bus.jogada_feita = 1'b0;
        esperar_estado(4'h7, 10, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL reach_proxima_rodada: estado=%h, required estado=7", bus.db_estado);
        end else $display("vector reach_proxima_rodada estado=%h", bus.db_estado);
        bus.jogada_feita = 1'b1;
        sb.push_back('{4'h2, O_INICIA});
        sb.push_back('{4'h3, O_NADA});
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            bus.jogada_feita = 1'b0;
            e = sb.pop_front(); n_vec++;
            if (bus.db_estado !== e.est || outs() !== e.o) begin
                n_err++;
                $display("FAIL play_ignored[%0d]: estado=%h outs=%b, required estado=%h outs=%b", i, bus.db_estado, outs(), e.est, e.o);
            end else $display("vector play_ignored[%0d] estado=%h outs=%b", i, bus.db_estado, outs());
        end
    endtask

    initial begin
        bus.iniciar = 1'b0;
        bus.jogada_feita = 1'b0;
        test_reset();
        test_vitoria();
        test_erro();
        test_timeout();
        test_reset_assincrono();
        test_robustez();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/controle_rodadas_jogo.md
Name: controle_rodadas_jogo

Overview:
- Control unit (FSM) that sequences the memory-game datapath: round limit counter, play address counter, play register, comparator.
- Walks the player through rounds of growing length and reports the outcome: win after the last round, error on a wrong play, or timeout when no play arrives in time.
- Contains the play-timeout counter.
- Sits beside the datapath inside the top-level game circuit; all datapath enables come from this block.

Parameters:
TIMEOUT_CICLOS, 5000, clock cycles allowed per play (5 s at 1 kHz); minimum 2.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
iniciar  in  1  start/restart request, level, sampled on clock
jogada_feita  in  1  one-cycle pulse from datapath edge detector: a key was pressed
jogada_correta  in  1  datapath comparator: registered play equals memory at current address
fim_jogadas  in  1  address counter equals round limit
fim_rodadas  in  1  round limit equals last round
zera_endereco  out  1  clear address counter
conta_endereco  out  1  increment address counter
zera_limite  out  1  clear round-limit counter
conta_limite  out  1  increment round-limit counter
zera_jogada  out  1  clear play register
registra_jogada  out  1  load play register from keys
pronto  out  1  game finished (any outcome)
acertou  out  1  game won
errou  out  1  wrong play
timeout  out  1  play not made in time
db_estado  out  4  current state code for 7-segment debug

Behaviour:
- Pure Moore machine: all outputs are decoded from the state register only. State and timeout counter reset asynchronously when reset=0.
- Reset state is inicial; every output is 0 and db_estado=0.
- inicial (0): if iniciar then preparacao.
- preparacao (1): zera_endereco=1, zera_limite=1, zera_jogada=1; next is inicia_rodada.
- inicia_rodada (2): zera_endereco=1; clears timeout counter; next is espera_jogada.
- espera_jogada (3): timeout counter increments each cycle.
  - jogada_feita then registra.
  - Else, when counter == TIMEOUT_CICLOS-1, next is fim_timeout.
  - fim_timeout is therefore entered exactly TIMEOUT_CICLOS cycles after entering espera_jogada.
  - jogada_feita in the same cycle as the terminal count: the play wins, go to registra.
- registra (4): registra_jogada=1; next is comparacao.
- comparacao (5): uses values registered the previous cycle.
  - !jogada_correta: fim_erro.
  - correct & !fim_jogadas: proxima_jogada.
  - correct & fim_jogadas & !fim_rodadas: proxima_rodada.
  - correct & fim_jogadas & fim_rodadas: fim_acerto.
- proxima_jogada (6): conta_endereco=1; clears timeout counter; next is espera_jogada.
- proxima_rodada (7): conta_limite=1; next is inicia_rodada.
- Terminal states (all hold until iniciar, then go to preparacao):
  - fim_acerto (A): pronto=1, acertou=1.
  - fim_erro (E): pronto=1, errou=1.
  - fim_timeout (B): pronto=1, timeout=1.
- iniciar is ignored in every state except inicial and the three terminal states.
- jogada_feita is ignored outside espera_jogada.
- Timeout counter width is $clog2(TIMEOUT_CICLOS). It saturates and never wraps. It counts only in espera_jogada and holds in all other states.
- Unused state codes go to inicial on the next clock.
- Reset low mid-operation returns to inicial immediately, regardless of clock.

Decomposition:
- Package jogo_pkg: state encoding localparams (INICIAL=4'h0 … FIM_ACERTO=4'hA, FIM_TIMEOUT=4'hB, FIM_ERRO=4'hE) and TIMEOUT_CICLOS default.
- One sub-module contador_timeout (ports zera, conta, fim; parameter M): the per-play counter, reusable by later experiments.

Test Plan:
1. Reset and start: hold reset=0 for 10 cycles → db_estado=0, all outputs 0. Release reset, pulse iniciar 1 cycle → states 1, 2, 3 on consecutive clocks.
2. Full win with a datapath model, 4 rounds, fim_rodadas asserted at limit=3:
   - Drive correct plays with jogada_feita pulses.
   - Required counts: conta_limite=3 pulses, conta_endereco=6 pulses.
   - Final state is A with pronto=1, acertou=1.
3. Error in round 4:
   - Plays 1 and 2 correct, play 3 with jogada_correta=0 → db_estado=E, errou=1, pronto=1, acertou=0.
   - iniciar → preparacao, errou=0.
4. Timeout, TIMEOUT_CICLOS=5000:
   - No jogada_feita → fim_timeout (db_estado=B, timeout=1) exactly 5000 cycles after entering state 3.
   - Rerun with jogada_feita on cycle 5000 (terminal count) → registra, timeout=0.
5. Async reset asserted mid espera_jogada, between clock edges → db_estado=0 before the next edge; outputs stay 0 until iniciar.
6. Robustness:
   - iniciar held high during espera_jogada → no effect.
   - jogada_feita pulsed in proxima_rodada → ignored, no registra_jogada.
